// File: rtl/keccak_mem_controller.sv
// keccak_mem_controller: sequences initial load, NUM_ROUNDS page sweeps with write-back handshake, and final save of the state memory
module keccak_mem_controller #(
    parameter int NUM_ROUNDS = 24,
    parameter int PAGES      = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       op_ready,
    output logic       load,
    output logic       save,
    output logic       write,
    output logic [5:0] page,
    output logic       op_valid,
    output logic [4:0] round,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, LOAD, PROC, SAVE, DONE} state_t;
    localparam logic [5:0] PAGE_MAX  = 6'(PAGES - 1);
    localparam logic [4:0] ROUND_MAX = 5'(NUM_ROUNDS - 1);
    state_t     state, state_nx;
    logic [5:0] page_nx;
    logic [4:0] round_nx;
    logic       last_page, last_round;
    assign last_page  = page == PAGE_MAX;
    assign last_round = round == ROUND_MAX;
    assign op_valid   = state == PROC;
    assign write      = op_valid & op_ready;
    assign busy       = state == LOAD || state == PROC || state == SAVE;
    assign done       = state == DONE;
    // next state and page/round advance; nothing moves in PROC without an accepted handshake
    always_comb begin
        state_nx = state;
        page_nx  = page;
        round_nx = round;
        case (state)
            IDLE: state_nx = start ? LOAD : IDLE;
            LOAD: state_nx = PROC;
            PROC: if (op_ready) begin
                page_nx  = last_page ? 6'd0 : page + 6'd1;
                round_nx = !last_page ? round : last_round ? 5'd0 : round + 5'd1;
                state_nx = last_page && last_round ? SAVE : PROC;
            end
            SAVE: state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // state, counters, and load/save strobes taken straight from flops so the memory sees glitch-free edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            page  <= '0;
            round <= '0;
            load  <= 1'b0;
            save  <= 1'b0;
        end else begin
            state <= state_nx;
            page  <= page_nx;
            round <= round_nx;
            load  <= state_nx == LOAD;
            save  <= state_nx == SAVE;
        end
    end
endmodule

// File: tb/tb_keccak_mem_controller.sv
// tb_keccak_mem_controller: directed checks of reset, full runs, stalls, wraps, ignored starts and abort
module tb_keccak_mem_controller;
    logic        clk = 1'b0, rst_n, start, op_ready;
    logic        load, save, write, op_valid, busy, done;
    logic [5:0]  page;
    logic [4:0]  round;
    logic [16:0] outs;
    int n_vec = 0, n_miss = 0, cyc = 0;
    int n_write = 0, n_load = 0, n_save = 0, n_order = 0, n_bad = 0, load_cyc = 0;
    int exp_page = 0, exp_round = 0;
    int w0, l0, s0, o0, b0, done_at;

    keccak_mem_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_ready(op_ready),
        .load(load), .save(save), .write(write), .page(page),
        .op_valid(op_valid), .round(round), .busy(busy), .done(done)
    );

    assign outs = {load, save, write, op_valid, busy, done, page, round};

    always #5 clk = ~clk;

    // cycle counter of rising edges
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: strobe counts, strobe overlaps, and write order against an independent page/round model
    always @(negedge clk) begin
        if (load) begin
            n_load++;
            load_cyc = cyc;
            exp_page = 0;
            exp_round = 0;
        end
        if (save) n_save++;
        if ((load && save) || (load && write) || (save && write)) n_bad++;
        if (write) begin
            n_write++;
            if (page != 6'(exp_page) || round != 5'(exp_round)) n_order++;
            exp_page++;
            if (exp_page == 64) begin
                exp_page = 0;
                exp_round = (exp_round + 1) % 24;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        w0 = n_write; l0 = n_load; s0 = n_save; o0 = n_order; b0 = n_bad;
    endtask

    task automatic kick();
        step(); start = 1'b1;
        step(); start = 1'b0;
    endtask

    task automatic wait_pr(input int p, input int r);
        bit hit = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            @(negedge clk);
            hit = page == 6'(p) && round == 5'(r);
        end
        chk("wait_page_round", 32'(hit), 1);
    endtask

    task automatic wait_done();
        bit hit = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            @(negedge clk);
            hit = done;
        end
        done_at = cyc;
        chk("wait_done", 32'(hit), 1);
    endtask

    task automatic run_totals(input string tag, input int lat);
        chk({tag, "_latency"}, done_at - load_cyc, lat);
        chk({tag, "_writes"}, n_write - w0, 1536);
        chk({tag, "_loads"}, n_load - l0, 1);
        chk({tag, "_saves"}, n_save - s0, 1);
        chk({tag, "_order"}, n_order - o0, 0);
        chk({tag, "_overlap"}, n_bad - b0, 0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; op_ready = 1'b1;
        #3 rst_n = 1'b0;
        #1 chk("rst_async", outs, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_after_rst", outs, 0);

        snap();
        kick();
        @(negedge clk); chk("load_pulse", {load, busy, op_valid}, 3'b110);
        @(negedge clk); chk("proc_entry", {load, op_valid, busy, page, round}, {3'b011, 11'd0});
        wait_pr(63, 0);
        @(negedge clk); chk("wrap_r0", {page, round}, {6'd0, 5'd1});
        wait_pr(63, 23);
        @(negedge clk); chk("wrap_last", {save, write, page, round}, {2'b10, 11'd0});
        wait_done();
        run_totals("full", 1538);
        @(negedge clk); chk("idle_after_run", {busy, done, op_valid}, 0);

        snap();
        kick();
        step(); op_ready = 1'b1;
        @(negedge clk); chk("stall0", {page, write}, {6'd0, 1'b1});
        step(); op_ready = 1'b0;
        @(negedge clk); chk("stall1", {page, write}, {6'd1, 1'b0});
        step(); op_ready = 1'b0;
        @(negedge clk); chk("stall2", {page, write}, {6'd1, 1'b0});
        step(); op_ready = 1'b1;
        @(negedge clk); chk("stall3", {page, write}, {6'd1, 1'b1});
        step();
        @(negedge clk); chk("stall4", {page, round}, {6'd2, 5'd0});
        wait_done();
        run_totals("stall", 1540);

        snap();
        kick();
        wait_pr(10, 3);
        start = 1'b1;
        step(); start = 1'b0;
        wait_pr(63, 23);
        start = 1'b1;
        step(); chk("in_save", {save, busy}, 2'b11);
        step(); start = 1'b0;
        wait_done();
        run_totals("busy_start", 1538);
        @(negedge clk); chk("no_restart", {busy, load}, 0);

        snap();
        kick();
        wait_pr(17, 5);
        #2 rst_n = 1'b0;
        #1 chk("abort_async", outs, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("abort_no_save", n_save - s0, 0);
        snap();
        kick();
        @(negedge clk); chk("reload", {load, page, round}, {1'b1, 11'd0});
        @(negedge clk); chk("rerun_entry", {op_valid, page, round}, {1'b1, 11'd0});
        wait_done();
        run_totals("rerun", 1538);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/keccak_mem_controller.md
# keccak_mem_controller

Sequencer for the 64-page × 25-bit state memory of the encoder. It loads the initial state, then sweeps every page once per round for `NUM_ROUNDS` rounds. Each sweep presents the current page to an external round unit and writes the result back under a valid/ready handshake. It finishes by pulsing the memory's save strobe and signalling completion. The block sits between the top-level encoder control and the state memory's `load`/`save`/`write`/`page` controls.

## Interface
- `NUM_ROUNDS`, 24, rounds per run (1..31)
- `PAGES`, 64, pages per round (power of two, ≤64)
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: run request, sampled in IDLE only.
- `op_ready` in 1: round unit has the result for `page` on the memory data input this cycle.
- `load` out 1: memory initial-load strobe, registered.
- `save` out 1: memory dump strobe, registered.
- `write` out 1: memory write enable; equals `op_valid & op_ready`.
- `page` out 6: memory page address.
- `op_valid` out 1: memory output for `page` is valid to the round unit.
- `round` out 5: current round index.
- `busy` out 1: high in LOAD, PROC and SAVE.
- `done` out 1: one-cycle completion pulse.

## Operation
- State machine has five states: IDLE, LOAD, PROC, SAVE, DONE.
- IDLE: all outputs 0, `page`=0, `round`=0. `start`=1 → LOAD.
- LOAD: `load`=1 for exactly one cycle, then → PROC with `page`=0 and `round`=0.
- PROC: `op_valid`=1, and `write` is asserted combinationally when `op_ready`=1.
  - On an accepted edge (`op_ready`=1), `page` increments.
  - At `page`=PAGES-1, `page` wraps to 0 and `round` increments.
  - At `page`=PAGES-1 with `round`=NUM_ROUNDS-1, the next state is SAVE; `page` and `round` return to 0.
  - With `op_ready`=0, `page`, `round` and state hold, and `write`=0.
- SAVE: `save`=1 for exactly one cycle, then → DONE.
- DONE: `done`=1 for one cycle, then → IDLE.
- `start` is ignored in every state except IDLE. A `start` held high in DONE's following IDLE cycle begins a new run.
- `load` and `save` drive asynchronously-sensitive memory inputs, so both must come directly from flops (glitch-free). They are never high in the same cycle, and never high together with `write`.
- `write` is 0 outside PROC regardless of `op_ready`.

## Timing
- Reset (`rst_n`=0, asynchronous) forces the following immediately, without waiting for a clock edge:
  - state IDLE
  - `page`=0, `round`=0
  - `load`=`save`=`write`=`op_valid`=`busy`=`done`=0
- Reset mid-run (any state) aborts the run. No `save` pulse is emitted; memory contents are left as-is.
- Take `start` sampled high at edge E0. Then:
  - `load` and `busy` are high during cycle E0→E1.
  - `op_valid` is high from E1.
- With `op_ready` tied to 1:
  - Writes occur at edges E2..E(1+NUM_ROUNDS·PAGES).
  - `save` is high during the following cycle.
  - `done` is high during cycle E(2+NUM_ROUNDS·PAGES)→E(3+NUM_ROUNDS·PAGES); for the defaults that is E1538.
- Every cycle of `op_ready`=0 in PROC delays SAVE and DONE by exactly one cycle.
- The page change is visible the cycle after acceptance. The memory read of the new page is combinational, so `op_valid` never deasserts between pages within a run.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle → all outputs 0 and `page`=0 immediately. Release with `start`=0 → outputs remain 0.
- Full run (defaults, `op_ready`=1): pulse `start` → `load` high 1 cycle; exactly 1536 `write` pulses covering page 0..63 for rounds 0..23 in order; `save` high 1 cycle with no `write`; `done` 1538 cycles after the start edge; `busy` low afterward.
- Stalls: drive `op_ready` with pattern 1,0,0,1 during round 0 → `page` goes 0→1, holds at 1 for 2 cycles, then 1→2. `write` is high only on ready cycles. `done` is delayed by the total stall count.
- Wrap: observe page 63 accepted in round 0 → next cycle `page`=0 and `round`=1. Observe page 63 accepted in round 23 → SAVE, with `page`=0 and `round`=0.
- Start while busy: pulse `start` in PROC and in SAVE → no extra `load`, and the run completes with 1536 writes.
- Abort: assert `rst_n`=0 at `round`=5, `page`=17 → IDLE with no `save` pulse. A new `start` reruns from `round`=0, `page`=0 with `load` pulsed again.
